ccff_chain_loader: RTL and testbench

Configuration-chain programmer that drives the `ccff_head`/`ccff_tail` scan chain formed by the switch-block, connection-block and grid configuration memories. It accepts the bitstream as bytes over a valid/ready stream and serialises it, one bit per `prog_clk`, into the chain head. It then verifies the load by recirculating the chain once (`ccff_tail` back to `ccff_head`) and comparing a CRC-8 of the tail stream against a CRC-8 of the loaded stream. The recirculation leaves the chain contents intact.

---
 rtl/ccff_chain_loader.sv | 154 +++++++++++++++
 tb/tb_ccff_chain_loader.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serialises a byte stream LSB first into the ccff scan chain,
// then recirculates the chain once and compares CRC-8 of the loaded and returned streams.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 12,
  parameter int CNT_W     = 16
) (
  input  logic       prog_clk,
  input  logic       prog_reset_n,
  input  logic       start,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] cfg_data,
  output logic       ccff_head,
  output logic       ccff_shift_en,
  input  logic       ccff_tail,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_VERIFY,
    S_CHECK,
    S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W:0]   TOTAL_BITS = (CNT_W+1)'(CHAIN_LEN);
  localparam logic [CNT_W:0]   BYTE_BITS  = (CNT_W+1)'(8);

  // CRC-8, polynomial 0x07, one bit per call.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  state_e           state_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [7:0]       buf_q;
  logic [3:0]       buf_cnt_q;
  logic [7:0]       crc_in_q;
  logic [7:0]       crc_out_q;
  logic             head_q;
  logic             error_q;

  logic             in_load;
  logic             in_verify;
  logic             load_shift;
  logic             accept;
  logic [CNT_W:0]   unbuffered;
  logic [3:0]       take_cnt;

  assign in_load   = (state_q == S_LOAD);
  assign in_verify = (state_q == S_VERIFY);

  // Chain bits neither shifted yet nor sitting in the byte buffer.
  assign unbuffered = TOTAL_BITS - {1'b0, bit_cnt_q} - {{(CNT_W-3){1'b0}}, buf_cnt_q};
  assign take_cnt   = (unbuffered >= BYTE_BITS) ? 4'd8 : unbuffered[3:0];

  assign load_shift    = in_load && (buf_cnt_q != 4'd0);
  assign cfg_ready     = in_load && (buf_cnt_q <= 4'd1) && (unbuffered != '0);
  assign accept        = cfg_valid && cfg_ready;
  assign ccff_shift_en = load_shift || in_verify;

  assign busy  = in_load || in_verify || (state_q == S_CHECK);
  assign done  = (state_q == S_DONE);
  assign error = error_q;

  always_comb begin
    // NOTE: default first so every path assigns ccff_head and no latch is inferred.
    ccff_head = head_q;
    if (in_verify) begin
      ccff_head = ccff_tail;
    end else if (load_shift) begin
      ccff_head = buf_q[0];
    end
  end

  // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      buf_q     <= '0;
      buf_cnt_q <= '0;
      crc_in_q  <= '0;
      crc_out_q <= '0;
      head_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      // Remembered so the head line holds steady through source stalls.
      if (ccff_shift_en) begin
        head_q <= ccff_head;
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q   <= S_LOAD;
            bit_cnt_q <= '0;
            buf_q     <= '0;
            buf_cnt_q <= '0;
            crc_in_q  <= '0;
            crc_out_q <= '0;
            error_q   <= 1'b0;
          end
        end

        S_LOAD: begin
          // A byte accepted while one bit remains replaces it as that bit shifts out.
          if (accept) begin
            buf_q     <= cfg_data;
            buf_cnt_q <= take_cnt;
          end else if (load_shift) begin
            buf_q     <= buf_q >> 1;
            buf_cnt_q <= buf_cnt_q - 4'd1;
          end

          if (load_shift) begin
            crc_in_q <= crc8_step(crc_in_q, buf_q[0]);
            if (bit_cnt_q == LAST_BIT) begin
              state_q   <= S_VERIFY;
              bit_cnt_q <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
        end

        S_VERIFY: begin
          crc_out_q <= crc8_step(crc_out_q, ccff_tail);
          if (bit_cnt_q == LAST_BIT) begin
            state_q <= S_CHECK;
          end else begin
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
          end
        end

        S_CHECK: begin
          error_q <= (crc_in_q != crc_out_q);
          state_q <= S_DONE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: 12-bit chain with a scoreboard on the head stream,
// plus 8- and 9-bit instances for the byte-boundary handshake counts.
module tb_ccff_chain_loader;

  localparam int LA = 12;

  logic prog_clk = 1'b0;
  logic prog_reset_n;
  always #5 prog_clk = ~prog_clk;

  int errors = 0;
  int checks = 0;
  bit exp_q[$];

  // 12-bit chain instance
  logic          start_a, valid_a;
  logic [7:0]    data_a;
  logic          ready_a, head_a, sen_a, busy_a, done_a, err_a;
  logic [LA-1:0] chain_a = '0;
  logic [LA-1:0] flip_a;

  ccff_chain_loader #(.CHAIN_LEN(LA), .CNT_W(16)) dut (
    .prog_clk      (prog_clk),
    .prog_reset_n  (prog_reset_n),
    .start         (start_a),
    .cfg_valid     (valid_a),
    .cfg_ready     (ready_a),
    .cfg_data      (data_a),
    .ccff_head     (head_a),
    .ccff_shift_en (sen_a),
    .ccff_tail     (chain_a[LA-1]),
    .busy          (busy_a),
    .done          (done_a),
    .error         (err_a)
  );

  always @(posedge prog_clk) begin
    if (sen_a) chain_a <= {chain_a[LA-2:0], head_a} ^ flip_a;
    else       chain_a <= chain_a ^ flip_a;
  end

  // 8- and 9-bit chain instances sharing one stimulus source
  logic       start_b, valid_b;
  logic [7:0] data_b;
  logic       ready8, head8, sen8, busy8, done8, err8;
  logic       ready9, head9, sen9, busy9, done9, err9;
  logic [7:0] chain8 = '0;
  logic [8:0] chain9 = '0;

  ccff_chain_loader #(.CHAIN_LEN(8), .CNT_W(8)) dut8 (
    .prog_clk      (prog_clk),
    .prog_reset_n  (prog_reset_n),
    .start         (start_b),
    .cfg_valid     (valid_b),
    .cfg_ready     (ready8),
    .cfg_data      (data_b),
    .ccff_head     (head8),
    .ccff_shift_en (sen8),
    .ccff_tail     (chain8[7]),
    .busy          (busy8),
    .done          (done8),
    .error         (err8)
  );

  ccff_chain_loader #(.CHAIN_LEN(9), .CNT_W(8)) dut9 (
    .prog_clk      (prog_clk),
    .prog_reset_n  (prog_reset_n),
    .start         (start_b),
    .cfg_valid     (valid_b),
    .cfg_ready     (ready9),
    .cfg_data      (data_b),
    .ccff_head     (head9),
    .ccff_shift_en (sen9),
    .ccff_tail     (chain9[8]),
    .busy          (busy9),
    .done          (done9),
    .error         (err9)
  );

  always @(posedge prog_clk) begin
    if (sen8) chain8 <= {chain8[6:0], head8};
    if (sen9) chain9 <= {chain9[7:0], head9};
  end

  // Full load/verify run on the 12-bit instance. Edge 0 is the edge that samples start.
  task automatic run12(input logic [7:0] b0, input logic [7:0] b1, input int gap_len,
                       input int flip_at, input int start_at, input bit chk_chain,
                       input logic [LA-1:0] exp_chain, input logic exp_err,
                       input int exp_done_edge, input string name);
    logic [7:0] bytes [2];
    int  e, bi, gap, acc_bits, load_sh, ver_sh, done_edge, take;
    bit  seen_done, post_load_seen, exp_bit;
    bytes[0] = b0;
    bytes[1] = b1;
    exp_q.delete();
    e = 0; bi = 0; gap = 0; acc_bits = 0; load_sh = 0; ver_sh = 0;
    done_edge = -1; seen_done = 0; post_load_seen = 0;

    @(negedge prog_clk);
    start_a = 1'b1;
    @(posedge prog_clk);
    #1;
    start_a = 1'b0;

    while (!seen_done && e < 200) begin
      flip_a  = '0;
      start_a = 1'b0;
      valid_a = (bi < 2) && (gap >= gap_len);
      data_a  = (bi < 2) ? bytes[bi] : 8'h00;
      @(negedge prog_clk);
      if (e == 0) begin
        checks++;
        if ({busy_a, err_a, done_a} !== 3'b100) begin
          errors++;
          $display("FAIL %s entry: busy/err/done got %b exp 100", name, {busy_a, err_a, done_a});
        end
      end
      if (done_a) begin
        seen_done = 1;
        done_edge = e;
      end else begin
        if (load_sh < LA) begin
          checks++;
          if (sen_a !== (acc_bits > load_sh)) begin
            errors++;
            $display("FAIL %s load_shift_en: got %b exp %b at edge %0d", name, sen_a,
                     (acc_bits > load_sh), e + 1);
          end
        end
        if (chk_chain && load_sh == LA && !post_load_seen) begin
          post_load_seen = 1;
          checks++;
          if (chain_a !== exp_chain) begin
            errors++;
            $display("FAIL %s chain_after_load: got %h exp %h", name, chain_a, exp_chain);
          end
        end
        if (sen_a) begin
          if (load_sh < LA) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL %s head: got %b exp <none queued> at edge %0d", name, head_a, e + 1);
            end else begin
              exp_bit = exp_q.pop_front();
              if (head_a !== exp_bit) begin
                errors++;
                $display("FAIL %s head: got %b exp %b at edge %0d", name, head_a, exp_bit, e + 1);
              end
            end
            load_sh++;
          end else begin
            checks++;
            if (head_a !== chain_a[LA-1]) begin
              errors++;
              $display("FAIL %s recirc_head: got %b exp %b", name, head_a, chain_a[LA-1]);
            end
            ver_sh++;
            if (ver_sh - 1 == flip_at) flip_a = 12'h008;
            if (ver_sh - 1 == start_at) start_a = 1'b1;
          end
        end
        if (acc_bits >= LA) begin
          checks++;
          if (ready_a !== 1'b0) begin
            errors++;
            $display("FAIL %s extra_ready: got %b exp 0 at edge %0d", name, ready_a, e);
          end
        end
        if (valid_a && ready_a) begin
          take = (LA - acc_bits < 8) ? (LA - acc_bits) : 8;
          for (int i = 0; i < take; i++) exp_q.push_back(bytes[bi][i]);
          acc_bits += take;
          bi++;
          gap = 0;
        end else if (ready_a && !valid_a) begin
          gap++;
        end
      end
      if (!seen_done) begin
        @(posedge prog_clk);
        #1;
        e++;
      end
    end
    valid_a = 1'b0;
    start_a = 1'b0;

    checks++;
    if (done_edge != exp_done_edge) begin
      errors++;
      $display("FAIL %s done_edge: got %0d exp %0d", name, done_edge, exp_done_edge);
    end
    checks++;
    if (err_a !== exp_err) begin
      errors++;
      $display("FAIL %s error: got %b exp %b", name, err_a, exp_err);
    end
    checks++;
    if (load_sh != LA || ver_sh != LA || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s shift_counts: got load=%0d verify=%0d left=%0d exp %0d/%0d/0", name,
               load_sh, ver_sh, exp_q.size(), LA, LA);
    end
    if (chk_chain) begin
      checks++;
      if (chain_a !== exp_chain) begin
        errors++;
        $display("FAIL %s chain_after_verify: got %h exp %h", name, chain_a, exp_chain);
      end
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge prog_clk);
      #1;
      checks++;
      if ({done_a, sen_a, busy_a, err_a} !== {1'b1, 1'b0, 1'b0, exp_err}) begin
        errors++;
        $display("FAIL %s done_hold: done/sen/busy/err got %b exp %b", name,
                 {done_a, sen_a, busy_a, err_a}, {1'b1, 1'b0, 1'b0, exp_err});
      end
    end
  endtask

  task automatic test_reset();
    prog_reset_n = 1'b0;
    #12;
    checks++;
    if ({ready_a, head_a, sen_a, busy_a, done_a, err_a, ready8, busy8, ready9, busy9} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b exp 0", {ready_a, head_a, sen_a, busy_a, done_a, err_a,
               ready8, busy8, ready9, busy9});
    end
    @(negedge prog_clk);
    prog_reset_n = 1'b1;
  endtask

  task automatic test_ignore_idle();
    valid_a = 1'b1;
    data_a  = 8'hFF;
    for (int c = 0; c < 4; c++) begin
      @(negedge prog_clk);
      checks++;
      if ({ready_a, sen_a, busy_a, done_a} !== 4'b0) begin
        errors++;
        $display("FAIL idle_valid: ready/sen/busy/done got %b exp 0000", {ready_a, sen_a, busy_a, done_a});
      end
    end
    valid_a = 1'b0;
  endtask

  task automatic test_basic();
    run12(8'hA5, 8'h03, 0, -1, -1, 1, 12'hA5C, 1'b0, 26, "basic");
  endtask

  task automatic test_flip();
    run12(8'hA5, 8'h03, 0, 2, -1, 0, 12'h000, 1'b1, 26, "flip");
  endtask

  task automatic test_stall();
    run12(8'hA5, 8'h03, 3, -1, -1, 1, 12'hA5C, 1'b0, 32, "stall");
  endtask

  task automatic test_start_in_verify();
    run12(8'hA5, 8'h03, 0, -1, 4, 1, 12'hA5C, 1'b0, 26, "start_verify");
  endtask

  task automatic test_exact_byte();
    logic [7:0] b0, b1, exp8;
    logic [8:0] exp9;
    int e, hs8, hs9, r8, r9, d8, d9;
    b0 = 8'h5A;
    b1 = 8'h01;
    exp8 = '0;
    for (int i = 0; i < 8; i++) exp8 = {exp8[6:0], b0[i]};
    exp9 = '0;
    for (int i = 0; i < 9; i++) exp9 = {exp9[7:0], (i < 8) ? b0[i] : b1[i-8]};
    e = 0; hs8 = 0; hs9 = 0; r8 = 0; r9 = 0; d8 = -1; d9 = -1;

    @(negedge prog_clk);
    start_b = 1'b1;
    @(posedge prog_clk);
    #1;
    start_b = 1'b0;
    valid_b = 1'b1;
    while ((d8 < 0 || d9 < 0) && e < 100) begin
      data_b = (hs9 == 0) ? b0 : b1;
      @(negedge prog_clk);
      if (done8 && d8 < 0) d8 = e;
      if (done9 && d9 < 0) d9 = e;
      if (ready8) r8++;
      if (ready9) r9++;
      if (valid_b && ready8) hs8++;
      if (valid_b && ready9) hs9++;
      @(posedge prog_clk);
      #1;
      e++;
    end
    valid_b = 1'b0;

    checks++;
    if (hs8 != 1 || r8 != 1) begin
      errors++;
      $display("FAIL len8_handshakes: got hs=%0d ready_cycles=%0d exp 1/1", hs8, r8);
    end
    checks++;
    if (hs9 != 2 || r9 != 2) begin
      errors++;
      $display("FAIL len9_handshakes: got hs=%0d ready_cycles=%0d exp 2/2", hs9, r9);
    end
    checks++;
    if (d8 != 18 || d9 != 20) begin
      errors++;
      $display("FAIL exact_done_edges: got %0d/%0d exp 18/20", d8, d9);
    end
    checks++;
    if (chain8 !== exp8 || chain9 !== exp9) begin
      errors++;
      $display("FAIL exact_chains: got %h/%h exp %h/%h", chain8, chain9, exp8, exp9);
    end
    checks++;
    if ({err8, err9} !== 2'b00) begin
      errors++;
      $display("FAIL exact_error: got %b exp 00", {err8, err9});
    end
  endtask

  task automatic test_reset_mid_load();
    int sh;
    sh = 0;
    @(negedge prog_clk);
    start_a = 1'b1;
    @(posedge prog_clk);
    #1;
    start_a = 1'b0;
    valid_a = 1'b1;
    data_a  = 8'hA5;
    for (int c = 0; c < 30 && sh < 5; c++) begin
      @(negedge prog_clk);
      if (sen_a) sh++;
      @(posedge prog_clk);
      #1;
    end
    checks++;
    if (sh != 5 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL midload_reach: got shifts=%0d busy=%b exp 5/1", sh, busy_a);
    end
    #2;
    prog_reset_n = 1'b0;
    #1;
    checks++;
    if ({ready_a, head_a, sen_a, busy_a, done_a, err_a} !== 6'b0) begin
      errors++;
      $display("FAIL midload_async_reset: got %b exp 000000", {ready_a, head_a, sen_a, busy_a, done_a, err_a});
    end
    valid_a = 1'b0;
    @(negedge prog_clk);
    prog_reset_n = 1'b1;
    run12(8'hFF, 8'h0F, 0, -1, -1, 1, 12'hFFF, 1'b0, 26, "after_reset");
  endtask

  initial begin
    start_a = 1'b0; valid_a = 1'b0; data_a = 8'h00; flip_a = '0;
    start_b = 1'b0; valid_b = 1'b0; data_b = 8'h00;
    test_reset();
    test_ignore_idle();
    test_basic();
    test_flip();
    test_stall();
    test_start_in_verify();
    test_exact_byte();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
